// File: rtl/screen_switch_n.sv
// Selects one of N parallel VGA streams for the mouse overlay stage. Screen changes come from
// clicks on the "next" button or forced requests, and are committed only at a frame boundary.
module screen_switch_n #(
  parameter int N_SCREENS = 4,
  parameter int CNT_W     = 12,
  parameter int RGB_W     = 12,
  parameter int BTN_X     = 352,
  parameter int BTN_Y     = 400,
  parameter int BTN_W     = 96,
  parameter int BTN_H     = 48,
  parameter int HOLDOFF   = 8,
  localparam int SEL_W    = $clog2(N_SCREENS)
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [N_SCREENS*CNT_W-1:0] hcount_in,
  input  logic [N_SCREENS*CNT_W-1:0] vcount_in,
  input  logic [N_SCREENS-1:0]       hsync_in,
  input  logic [N_SCREENS-1:0]       vsync_in,
  input  logic [N_SCREENS-1:0]       hblnk_in,
  input  logic [N_SCREENS-1:0]       vblnk_in,
  input  logic [N_SCREENS*RGB_W-1:0] rgb_in,
  input  logic                       mouse_left,
  input  logic [CNT_W-1:0]           xpos,
  input  logic [CNT_W-1:0]           ypos,
  input  logic                       force_valid,
  input  logic [SEL_W-1:0]           force_sel,
  output logic [CNT_W-1:0]           hcount_out,
  output logic [CNT_W-1:0]           vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       hblnk_out,
  output logic                       vblnk_out,
  output logic [RGB_W-1:0]           rgb_out,
  output logic [SEL_W-1:0]           sel,
  output logic                       busy
);

  localparam logic [CNT_W:0]   BX0      = (CNT_W+1)'(BTN_X);
  localparam logic [CNT_W:0]   BX1      = (CNT_W+1)'(BTN_X + BTN_W);
  localparam logic [CNT_W:0]   BY0      = (CNT_W+1)'(BTN_Y);
  localparam logic [CNT_W:0]   BY1      = (CNT_W+1)'(BTN_Y + BTN_H);
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W+1)'(N_SCREENS);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_SCREENS - 1);
  localparam logic [7:0]       HOLD_INI = 8'(HOLDOFF - 1);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_HOLDOFF} state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_target;
  logic [7:0]       r_hold;
  logic             r_left_q;
  logic             r_vblnk_q;

  logic [CNT_W-1:0] r_hcount_p1;
  logic [CNT_W-1:0] r_vcount_p1;
  logic             r_hsync_p1;
  logic             r_vsync_p1;
  logic             r_hblnk_p1;
  logic             r_vblnk_p1;
  logic [RGB_W-1:0] r_rgb_p1;

  logic [CNT_W-1:0] w_hcount;
  logic [CNT_W-1:0] w_vcount;
  logic [RGB_W-1:0] w_rgb;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_hblnk;
  logic             w_vblnk;
  logic             w_click;
  logic             w_in_btn;
  logic             w_fb;
  logic             w_force_ok;
  logic [SEL_W-1:0] w_next;
  logic [CNT_W:0]   w_x;
  logic [CNT_W:0]   w_y;

  // Stream mux driven by the committed selection
  always_comb begin
    w_hcount = hcount_in[int'(r_sel)*CNT_W +: CNT_W];
    w_vcount = vcount_in[int'(r_sel)*CNT_W +: CNT_W];
    w_rgb    = rgb_in[int'(r_sel)*RGB_W +: RGB_W];
    w_hsync  = hsync_in[r_sel];
    w_vsync  = vsync_in[r_sel];
    w_hblnk  = hblnk_in[r_sel];
    w_vblnk  = vblnk_in[r_sel];
  end

  // One extra bit keeps the right/bottom edge sums from wrapping near the screen limit
  assign w_x        = {1'b0, xpos};
  assign w_y        = {1'b0, ypos};
  assign w_in_btn   = (w_x >= BX0) && (w_x < BX1) && (w_y >= BY0) && (w_y < BY1);
  assign w_click    = mouse_left & ~r_left_q;
  assign w_fb       = w_vblnk & ~r_vblnk_q;
  assign w_force_ok = force_valid && ({1'b0, force_sel} < N_LIM);
  assign w_next     = (r_sel == LAST_SEL) ? '0 : r_sel + 1'b1;

  // p0 -> p1: registered outputs and selection control
  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_target    <= '0;
      r_hold      <= '0;
      r_left_q    <= 1'b0;
      r_vblnk_q   <= 1'b0;
      r_hcount_p1 <= '0;
      r_vcount_p1 <= '0;
      r_hsync_p1  <= 1'b0;
      r_vsync_p1  <= 1'b0;
      r_hblnk_p1  <= 1'b0;
      r_vblnk_p1  <= 1'b0;
      r_rgb_p1    <= '0;
    end else begin
      r_left_q    <= mouse_left;
      r_vblnk_q   <= w_vblnk;
      r_hcount_p1 <= w_hcount;
      r_vcount_p1 <= w_vcount;
      r_hsync_p1  <= w_hsync;
      r_vsync_p1  <= w_vsync;
      r_hblnk_p1  <= w_hblnk;
      r_vblnk_p1  <= w_vblnk;
      r_rgb_p1    <= w_rgb;
      case (r_state)
        S_IDLE: begin
          // A simultaneous force request always discards the click, even an out-of-range one
          if (w_force_ok) begin
            r_target <= force_sel;
            r_state  <= S_PENDING;
          end else if (!force_valid && w_click && w_in_btn) begin
            r_target <= w_next;
            r_state  <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (w_fb) begin
            r_sel   <= w_force_ok ? force_sel : r_target;
            r_hold  <= HOLD_INI;
            r_state <= S_HOLDOFF;
          end else if (w_force_ok) begin
            r_target <= force_sel;
          end
        end
        S_HOLDOFF: begin
          if (w_force_ok) begin
            r_target <= force_sel;
            r_state  <= S_PENDING;
          end else if (w_fb) begin
            if (r_hold == 8'd0) r_state <= S_IDLE;
            else                r_hold  <= r_hold - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hcount_out = r_hcount_p1;
  assign vcount_out = r_vcount_p1;
  assign hsync_out  = r_hsync_p1;
  assign vsync_out  = r_vsync_p1;
  assign hblnk_out  = r_hblnk_p1;
  assign vblnk_out  = r_vblnk_p1;
  assign rgb_out    = r_rgb_p1;
  assign sel        = r_sel;
  assign busy       = (r_state != S_IDLE);

endmodule
